// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative unsigned multiply/divide sequencer beside EX.
// Holds the pipeline with stall until the result is presented with ack.
module ex_muldiv_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    output logic              stall,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] result,
    output logic              div_zero
);

    localparam logic [1:0] OP_MULU_LO = 2'b00;
    localparam logic [1:0] OP_MULU_HI = 2'b01;
    localparam logic [1:0] OP_DIVU    = 2'b10;
    localparam logic [1:0] OP_REMU    = 2'b11;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [1:0]          op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvsr_q;

    logic start_run;
    logic start_dz;
    logic last_step;

    logic [DATA_W-1:0]   mul_add;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] prod_nxt;

    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     div_t;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;

    logic [DATA_W-1:0]   res_nxt;
    logic [DATA_W-1:0]   dz_res;

    logic is_lo;
    logic is_hi;
    logic is_div;
    logic is_rem;

    // The pipeline is held until the cycle the result is acked.
    assign stall = req & (state_q != ST_DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush beats every transition.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        start_dz  = 1'b0;
        last_step = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (op[1] && (in_1 == '0)) begin
                            state_d  = ST_DONE;
                            start_dz = 1'b1;
                        end else begin
                            state_d   = ST_RUN;
                            start_run = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d   = ST_DONE;
                        last_step = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // One shift-add multiply step; the carry out of the add is kept.
    always_comb begin
        mul_add  = prod_q[0] ? mcand_q : '0;
        mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                 + {1'b0, mul_add};
        prod_nxt = {mul_sum, prod_q[DATA_W-1:1]};
    end

    // One restoring divide step on a W+1 bit partial remainder.
    always_comb begin
        rem_sh  = {rem_q, quo_q[DATA_W-1]};
        div_t   = rem_sh - {1'b0, dvsr_q};
        quo_nxt = {quo_q[DATA_W-2:0], ~div_t[DATA_W]};
        if (div_t[DATA_W]) begin
            rem_nxt = rem_sh[DATA_W-1:0];
        end else begin
            rem_nxt = div_t[DATA_W-1:0];
        end
    end

    // Pick the final result from the values the last step produces.
    always_comb begin
        is_lo   = (op_q == OP_MULU_LO);
        is_hi   = (op_q == OP_MULU_HI);
        is_div  = (op_q == OP_DIVU);
        is_rem  = (op_q == OP_REMU);
        res_nxt = '0;
        unique case (1'b1)
            is_lo:   res_nxt = prod_nxt[DATA_W-1:0];
            is_hi:   res_nxt = prod_nxt[2*DATA_W-1:DATA_W];
            is_div:  res_nxt = quo_nxt;
            is_rem:  res_nxt = rem_nxt;
            default: res_nxt = '0;
        endcase
        dz_res = op[0] ? in_0 : '1;
    end

    // Status flags track the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            ack      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= (state_d == ST_RUN);
            ack      <= (state_d == ST_DONE);
            div_zero <= start_dz;
        end
    end

    // Operand capture, iteration and result load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            result  <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (start_dz) begin
            result <= dz_res;
        end else if (start_run) begin
            op_q    <= op;
            cnt_q   <= '0;
            prod_q  <= {{DATA_W{1'b0}}, in_0};
            mcand_q <= in_1;
            rem_q   <= '0;
            quo_q   <= in_0;
            dvsr_q  <= in_1;
        end else if (state_q == ST_RUN) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            prod_q <= prod_nxt;
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
            if (last_step) begin
                result <= res_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: scoreboard bench for the EX mul/div sequencer.
// Expected results come from plain 64-bit arithmetic on the operands.
module tb_ex_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         req = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] in_0 = '0;
    logic [W-1:0] in_1 = '0;
    logic         stall;
    logic         busy;
    logic         ack;
    logic [W-1:0] result;
    logic         div_zero;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        bit          dz;
        int          at;
    } exp_t;

    exp_t sbq[$];

    ex_muldiv_ctrl #(
        .DATA_W(W),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .req     (req),
        .op      (op),
        .in_0    (in_0),
        .in_1    (in_1),
        .stall   (stall),
        .busy    (busy),
        .ack     (ack),
        .result  (result),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input int t0);
        exp_t e;
        logic [63:0] p;
        p    = {32'b0, a} * {32'b0, b};
        e.dz = 1'b0;
        e.at = t0 + 33;
        case (o)
            2'd0: e.res = p[31:0];
            2'd1: e.res = p[63:32];
            2'd2: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: e.res = (b == 0) ? a : a % b;
        endcase
        if (o[1] && b == 0) begin
            e.dz = 1'b1;
            e.at = t0 + 1;
        end
        return e;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ack === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack=1 expected none (cycle %0d)",
                         cyc);
            end else begin
                e = sbq.pop_front();
                check("ack_result", result, e.res);
                check("ack_div_zero", {31'b0, div_zero}, {31'b0, e.dz});
                check("ack_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_ack(input int t0, input bit dz, input bit scr);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (stall) n++;
            if (!dz && cyc == t0 + 1) check("busy_run", {31'b0, busy}, 1);
            if (ack) begin
                done = 1'b1;
            end else if (cyc - t0 > 100) begin
                checks++;
                failures++;
                $display("FAIL ack_timeout: got no ack expected ack by cycle %0d",
                         t0 + 33);
                done = 1'b1;
            end else begin
                #1;
                if (scr && cyc > t0) begin
                    in_0 = $urandom;
                    in_1 = $urandom;
                    op   = 2'($urandom);
                end
            end
        end
        check("stall_cycles", n, dz ? 1 : 33);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input bit scr);
        int t0;
        @(posedge clk);
        #1;
        req  = 1'b1;
        op   = o;
        in_0 = a;
        in_1 = b;
        t0   = cyc;
        sbq.push_back(model(o, a, b, t0));
        wait_ack(t0, o[1] && (b == 0), scr);
        req = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Asynchronous reset mid-cycle, before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_result", result, 0);
        check("rst_flags", {28'b0, ack, busy, div_zero, stall}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'd100, 32'd7, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'd1, 1'b0);
        run_op(2'd2, 32'h0000_1234, 32'd0, 1'b0);
        run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0);

        // Flush during a divide: no ack, back to idle.
        @(posedge clk);
        #1;
        req  = 1'b1;
        op   = 2'd2;
        in_0 = $urandom;
        in_1 = 32'd7;
        t0   = cyc;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        req   = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, busy}, 0);
        check("flush_ack", {31'b0, ack}, 0);
        repeat (3) @(posedge clk);
        run_op(2'd0, 32'd3, 32'd5, 1'b1);

        // Back-to-back: req held through DONE, op changed to REMU 17/5.
        @(posedge clk);
        #1;
        req  = 1'b1;
        op   = 2'd2;
        in_0 = 32'd1000;
        in_1 = 32'd3;
        t0   = cyc;
        sbq.push_back(model(2'd2, 32'd1000, 32'd3, t0));
        wait_ack(t0, 1'b0, 1'b0);
        op   = 2'd3;
        in_0 = 32'd17;
        in_1 = 32'd5;
        t1   = cyc + 1;
        sbq.push_back(model(2'd3, 32'd17, 32'd5, t1));
        check("b2b_gap", t1 + 33 - (t0 + 33), 34);
        wait_ack(t1, 1'b0, 1'b0);
        req = 1'b0;

        // Reset in the middle of a multiply.
        @(posedge clk);
        #1;
        req  = 1'b1;
        op   = 2'd0;
        in_0 = $urandom;
        in_1 = $urandom;
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        req   = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_flags", {28'b0, ack, busy, div_zero, stall}, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        // Randomized operations, some with operands scrambled in RUN.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        check("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
